// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo push arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req_i at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotate so that the requester at ptr_i lands on bit 0.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N-1:0];

  // Lowest set bit of the rotated vector, then map back to an absolute index.
  always_comb begin
    off   = '0;
    any_o = |rot;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum   = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin owner of the shared fifo push port with per-grant burst lock.
// Optional per-requester beat counters: define FIFO_ARB_STATS_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int D_WIDTH   = 4,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*D_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_push,
  output logic [ID_W+D_WIDTH-1:0]    fifo_din,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic                       fifo_pop,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,output logic [NUM_REQ*STAT_W-1:0] stat_beats
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q;
  logic [ID_W-1:0]    grant_q, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               slot_ok, own_valid, own_last, accept, rel;
  logic               pick_any;
  logic [ID_W-1:0]    pick_idx;
  logic [D_WIDTH-1:0] own_data;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A consumer pop steals the fifo's write slot for that cycle.
  assign slot_ok   = !fifo_full && !(fifo_pop && !fifo_empty);
  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[grant_q*D_WIDTH +: D_WIDTH];
  assign busy      = (state_q == BURST);
  assign accept    = busy && own_valid && slot_ok;
  assign fifo_push = accept;
  assign fifo_din  = busy ? {grant_q, own_data} : '0;
  assign grant_id  = grant_q;

  // Burst ends on last, on hitting the beat cap, or when the owner goes idle.
  assign rel = busy && (!own_valid ||
               (accept && (own_last || beat_cnt_q == CNT_W'(MAX_BURST - 1))));
  assign rr_ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign beat_cnt_d = beat_cnt_q + 1'b1;

  // Only the owner sees ready, and only when the fifo can take a word.
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_q] = slot_ok;
  end

  // Arbitration / burst FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (rel) begin
            state_q    <= IDLE;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= '0;
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    // Saturating accepted-beat counter for requester g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stat_q[g] <= '0;
      else if (accept && grant_q == ID_W'(g) && stat_q[g] != '1)
        stat_q[g] <= stat_q[g] + 1'b1;
    end
  end

  assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter against a cycle-level rule model.
module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_push;
  logic [IW+DW-1:0] fifo_din;
  logic            fifo_full = 1'b0;
  logic            fifo_empty = 1'b1;
  logic            fifo_pop = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
`endif

  int checks = 0;
  int errors = 0;
  // model: owner<0 means nobody holds the port
  int owner = -1;
  int ptr = 0;
  int beats = 0;
  int stats[N];
  int rem[N];

  always #5 clk = ~clk;

  fifo_push_arbiter #(.NUM_REQ(N), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_beats(stat_beats)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic newword(input int i);
    req_data[i*DW +: DW] = DW'($urandom);
    req_last[i] = (rem[i] == 1);
  endtask

  task automatic after_acc(input bit acc, input int who);
    if (acc) begin
      rem[who]--;
      if (rem[who] <= 0) begin
        req_valid[who] = 1'b0;
        req_last[who]  = 1'b0;
      end else newword(who);
    end
  endtask

  // Called at posedge+1 with inputs settled; checks mid-cycle, advances model.
  task automatic cyc(output bit acc, output int who, output bit ob, output int og, output bit op);
    bit slot, push_e;
    bit found;
    logic [N-1:0] rdy_e;
    #3;
    slot   = !fifo_full && !(fifo_pop && !fifo_empty);
    rdy_e  = '0;
    push_e = 1'b0;
    if (owner >= 0) begin
      if (slot) rdy_e[owner] = 1'b1;
      push_e = req_valid[owner] && slot;
    end
    ob = busy; og = int'(grant_id); op = fifo_push;
    chk("busy", busy, owner >= 0);
    chk("req_ready", req_ready, rdy_e);
    chk("fifo_push", fifo_push, push_e);
    if (owner >= 0) chk("grant_id", grant_id, owner);
    if (push_e) chk("fifo_din", fifo_din, {owner[IW-1:0], req_data[owner*DW +: DW]});
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_beats", stat_beats[i*16 +: 16], stats[i]);
`endif
    acc = push_e;
    who = owner;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (!found && req_valid[c]) begin
          owner = c; beats = 0; found = 1'b1;
        end
      end
    end else begin
      if (push_e) begin
        beats++;
        if (stats[owner] < 65535) stats[owner]++;
      end
      if (!req_valid[owner] || (push_e && (req_last[owner] || beats == MB))) begin
        ptr = (owner + 1) % N; owner = -1; beats = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, '0);
    chk("rst_push", fifo_push, 1'b0);
    chk("rst_gid", grant_id, '0);
    chk("rst_din", fifo_din, '0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_stats", stat_beats, '0);
`endif
    owner = -1; ptr = 0; beats = 0;
    for (int i = 0; i < N; i++) stats[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc, ob, op, pb;
    int who, og, k, cnt;
    for (int i = 0; i < N; i++) begin stats[i] = 0; rem[i] = 0; end
    @(posedge clk); #1;
    do_reset();

    // single requester, 3-word packet
    rem[2] = 3; req_valid[2] = 1'b1; newword(2);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(acc, who, ob, og, op);
      if (op) cnt++;
      after_acc(acc, who);
    end
    chk("t1_pushes", cnt, 3);
    // pointer now sits at 3: contention goes to 3 first
    for (int i = 0; i < N; i++) begin rem[i] = 1000; req_valid[i] = 1'b1; newword(i); end
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    chk("t1_next_gid", og, 3);
    do_reset();

    // full contention, no last: 0,1,2,3,0 with 4 beats each
    k = 0; cnt = 0; pb = 1'b0;
    for (int c = 0; c < 26; c++) begin
      cyc(acc, who, ob, og, op);
      if (ob && !pb && k < 5) begin chk("t2_order", og, k % N); k++; cnt = 0; end
      if (!ob && pb) chk("t2_beats", cnt, MB);
      if (op) cnt++;
      pb = ob;
      after_acc(acc, who);
    end
    req_valid = '0; req_last = '0;
    do_reset();

    // stall 5 cycles at beat 2
    rem[0] = 1000; req_valid[0] = 1'b1; newword(0);
    cnt = 0;
    for (int c = 0; c < 20 && (c < 2 || owner >= 0); c++) begin
      if (cnt == 2 && c < 10) fifo_full = 1'b1;
      cyc(acc, who, ob, og, op);
      if (op) cnt++;
      if (fifo_full && c >= 7) fifo_full = 1'b0;
      after_acc(acc, who);
    end
    fifo_full = 1'b0;
    chk("t3_beats", cnt, MB);
    chk("t3_released", owner, -1);
    req_valid = '0;
    do_reset();

    // pop steals the slot only when the fifo is non-empty
    rem[1] = 1000; req_valid[1] = 1'b1; newword(1);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    fifo_pop = 1'b1; fifo_empty = 1'b0;
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    chk("t4_pop_block", op, 1'b0);
    fifo_empty = 1'b1;
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    chk("t4_pop_empty", op, 1'b1);
    fifo_pop = 1'b0;
    req_valid = '0;
    do_reset();

    // owner drops valid after 1 beat
    rem[1] = 1000; req_valid[1] = 1'b1; newword(1);
    rem[3] = 1000; req_valid[3] = 1'b1; newword(3);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    req_valid[1] = 1'b0;
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    chk("t5_busy", ob, 1'b1);
    chk("t5_next_gid", og, 3);
    req_valid = '0; req_last = '0;

    // randomized traffic with backpressure and pops
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 400; c++) begin
      fifo_full  = ($urandom_range(0, 4) == 0);
      fifo_pop   = 1'($urandom_range(0, 1));
      fifo_empty = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          rem[i] = $urandom_range(1, 6);
          req_valid[i] = 1'b1;
          newword(i);
        end
      end
      cyc(acc, who, ob, og, op);
      after_acc(acc, who);
    end
    fifo_full = 1'b0; fifo_pop = 1'b0; fifo_empty = 1'b1;

    // reset mid-burst, then contention restarts at requester 0
    for (int i = 0; i < N; i++) begin rem[i] = 1000; req_valid[i] = 1'b1; newword(i); end
    for (int c = 0; c < 3; c++) begin cyc(acc, who, ob, og, op); after_acc(acc, who); end
    do_reset();
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    cyc(acc, who, ob, og, op); after_acc(acc, who);
    chk("t6_first_gid", og, 0);
    for (int c = 0; c < 6; c++) begin cyc(acc, who, ob, og, op); after_acc(acc, who); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
